// File: rtl/raycast_hit_resolver.sv
// Reduces per-pixel raycast results (primary group + one shadow group per light)
// to a single resolved-pixel record: nearest hit plus per-light visibility mask.
module raycast_hit_resolver #(
  parameter int NUM_SHAPES = 8,
  parameter int NUM_LIGHTS = 4,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int SHAPE_AW   = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1,
  parameter int LIGHT_AW   = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic                  res_hit,
  input  logic [15:0]           res_sq_distance,
  input  logic [47:0]           res_intersection,
  input  logic [SHAPE_AW-1:0]   res_shape_addr,
  input  logic                  res_is_shadow,
  input  logic [LIGHT_AW-1:0]   res_light_addr,
  input  logic                  res_last,
  input  logic [X_W-1:0]        res_pixel_x,
  input  logic [Y_W-1:0]        res_pixel_y,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [X_W-1:0]        pix_x,
  output logic [Y_W-1:0]        pix_y,
  output logic                  pix_hit,
  output logic [SHAPE_AW-1:0]   pix_shape_addr,
  output logic [47:0]           pix_intersection,
  output logic [15:0]           pix_sq_distance,
  output logic [NUM_LIGHTS-1:0] pix_light_mask,
  output logic                  proto_err
);

  typedef enum logic [1:0] {PRIMARY, SHADOW, EMIT} state_t;

  localparam logic [15:0] POS_INF = 16'h7C00;

  state_t                state;
  logic [15:0]           best_dist;
  logic [47:0]           best_isect;
  logic [SHAPE_AW-1:0]   best_shape;
  logic                  best_hit;
  logic [X_W-1:0]        tag_x;
  logic [Y_W-1:0]        tag_y;
  logic                  have_tag;
  logic [LIGHT_AW-1:0]   light_cnt;
  logic [NUM_LIGHTS-1:0] mask;

  logic                  xfer, tag_bad, dist_nan, cand, prim_err, shad_err, take, occlude;
  logic [15:0]           nb_dist;
  logic [47:0]           nb_isect;
  logic [SHAPE_AW-1:0]   nb_shape;
  logic                  nb_hit;
  logic [X_W-1:0]        nb_x;
  logic [Y_W-1:0]        nb_y;
  logic [NUM_LIGHTS-1:0] nmask;

  assign xfer     = res_valid && res_ready;
  assign tag_bad  = have_tag && ((res_pixel_x != tag_x) || (res_pixel_y != tag_y));
  assign dist_nan = (&res_sq_distance[14:10]) && (|res_sq_distance[9:0]);
  // Magnitude compare on [14:0] is only meaningful for non-negative, non-NaN values.
  assign cand     = res_hit && !res_sq_distance[15] && !dist_nan
                    && (res_sq_distance[14:0] < best_dist[14:0]);
  assign prim_err = res_is_shadow || tag_bad;
  assign shad_err = !res_is_shadow || tag_bad || (res_light_addr != light_cnt);
  assign take     = !prim_err && cand;
  assign occlude  = !shad_err && res_hit && (res_shape_addr != best_shape);

  // Best/tag view including the result accepted this cycle, used when the group closes.
  assign nb_dist  = take ? res_sq_distance  : best_dist;
  assign nb_isect = take ? res_intersection : best_isect;
  assign nb_shape = take ? res_shape_addr   : best_shape;
  assign nb_hit   = take || best_hit;
  assign nb_x     = (!have_tag && !prim_err) ? res_pixel_x : tag_x;
  assign nb_y     = (!have_tag && !prim_err) ? res_pixel_y : tag_y;
  assign nmask    = occlude ? (mask & ~(NUM_LIGHTS'(1) << res_light_addr)) : mask;

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      state            <= PRIMARY;
      res_ready        <= 1'b1;
      pix_valid        <= 1'b0;
      pix_x            <= '0;
      pix_y            <= '0;
      pix_hit          <= 1'b0;
      pix_shape_addr   <= '0;
      pix_intersection <= '0;
      pix_sq_distance  <= '0;
      pix_light_mask   <= '0;
      best_dist        <= POS_INF;
      best_isect       <= '0;
      best_shape       <= '0;
      best_hit         <= 1'b0;
      tag_x            <= '0;
      tag_y            <= '0;
      have_tag         <= 1'b0;
      light_cnt        <= '0;
      mask             <= '0;
      if (rst) proto_err <= 1'b0;
    end else begin
      case (state)
        PRIMARY: if (xfer) begin
          if (prim_err) begin
            proto_err <= 1'b1;
          end else begin
            tag_x      <= nb_x;
            tag_y      <= nb_y;
            have_tag   <= 1'b1;
            best_dist  <= nb_dist;
            best_isect <= nb_isect;
            best_shape <= nb_shape;
            best_hit   <= nb_hit;
          end
          if (res_last) begin
            if (!nb_hit) begin
              state            <= EMIT;
              res_ready        <= 1'b0;
              pix_valid        <= 1'b1;
              pix_x            <= nb_x;
              pix_y            <= nb_y;
              pix_hit          <= 1'b0;
              pix_shape_addr   <= nb_shape;
              pix_intersection <= nb_isect;
              pix_sq_distance  <= nb_dist;
              pix_light_mask   <= '0;
              mask             <= '0;
            end else begin
              state     <= SHADOW;
              mask      <= '1;
              light_cnt <= '0;
            end
          end
        end
        SHADOW: if (xfer) begin
          if (shad_err) proto_err <= 1'b1;
          mask <= nmask;
          if (res_last) begin
            light_cnt <= light_cnt + 1'b1;
            if (light_cnt == LIGHT_AW'(NUM_LIGHTS - 1)) begin
              state            <= EMIT;
              res_ready        <= 1'b0;
              pix_valid        <= 1'b1;
              pix_x            <= tag_x;
              pix_y            <= tag_y;
              pix_hit          <= best_hit;
              pix_shape_addr   <= best_shape;
              pix_intersection <= best_isect;
              pix_sq_distance  <= best_dist;
              pix_light_mask   <= nmask;
            end
          end
        end
        EMIT: if (pix_ready) begin
          state      <= PRIMARY;
          res_ready  <= 1'b1;
          pix_valid  <= 1'b0;
          best_dist  <= POS_INF;
          best_isect <= '0;
          best_shape <= '0;
          best_hit   <= 1'b0;
          have_tag   <= 1'b0;
          light_cnt  <= '0;
          mask       <= '0;
        end
        default: state <= PRIMARY;
      endcase
    end
  end

endmodule

// File: tb/tb_raycast_hit_resolver.sv
// Directed-vector bench for raycast_hit_resolver.
module tb_raycast_hit_resolver;

  logic        clk = 1'b0;
  logic        rst, frame_start, res_valid, res_ready, res_hit, res_is_shadow, res_last;
  logic [15:0] res_sq_distance;
  logic [47:0] res_intersection;
  logic [2:0]  res_shape_addr;
  logic [1:0]  res_light_addr;
  logic [8:0]  res_pixel_x;
  logic [7:0]  res_pixel_y;
  logic        pix_valid, pix_ready, pix_hit, proto_err;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [2:0]  pix_shape_addr;
  logic [47:0] pix_intersection;
  logic [15:0] pix_sq_distance;
  logic [3:0]  pix_light_mask;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  raycast_hit_resolver dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_sq_distance(res_sq_distance), .res_intersection(res_intersection),
    .res_shape_addr(res_shape_addr), .res_is_shadow(res_is_shadow),
    .res_light_addr(res_light_addr), .res_last(res_last),
    .res_pixel_x(res_pixel_x), .res_pixel_y(res_pixel_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_hit(pix_hit), .pix_shape_addr(pix_shape_addr),
    .pix_intersection(pix_intersection), .pix_sq_distance(pix_sq_distance),
    .pix_light_mask(pix_light_mask), .proto_err(proto_err)
  );

  // Present one result; returns 1 ns after the accepting edge.
  task automatic send(input logic hit, input logic [15:0] d, input logic [47:0] isect,
                      input logic [2:0] shape, input logic sh, input logic [1:0] light,
                      input logic last, input logic [8:0] x, input logic [7:0] y);
    int n;
    @(negedge clk);
    res_valid = 1'b1; res_hit = hit; res_sq_distance = d; res_intersection = isect;
    res_shape_addr = shape; res_is_shadow = sh; res_light_addr = light;
    res_last = last; res_pixel_x = x; res_pixel_y = y;
    n = 0;
    while (!res_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!res_ready) begin
      checks++;
      $display("FAIL send_timeout: res_ready=%0b required 1", res_ready);
    end
    @(posedge clk);
    #1 res_valid = 1'b0; res_last = 1'b0;
  endtask

  task automatic shadow_miss(input logic [1:0] light, input logic [8:0] x, input logic [7:0] y);
    send(1'b0, 16'h4000, 48'h0, 3'd0, 1'b1, light, 1'b1, x, y);
  endtask

  // Hold the pixel for 'hold' cycles checking stability, then accept it.
  task automatic pop_pixel(input int hold, input logic hit, input logic [2:0] shape,
                           input logic [15:0] d, input logic [3:0] m,
                           input logic [8:0] x, input logic [7:0] y);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (res_ready !== 1'b0 || pix_valid !== 1'b1 || pix_hit !== hit ||
          pix_shape_addr !== shape || pix_sq_distance !== d ||
          pix_light_mask !== m || pix_x !== x || pix_y !== y)
        $display("FAIL hold_stable cyc %0d: rdy=%0b vld=%0b hit=%0b shp=%0d d=%h m=%b xy=%0d,%0d required 0 1 %0b %0d %h %b %0d,%0d",
                 i, res_ready, pix_valid, pix_hit, pix_shape_addr, pix_sq_distance,
                 pix_light_mask, pix_x, pix_y, hit, shape, d, m, x, y);
      else passed++;
    end
    @(negedge clk);
    pix_ready = 1'b1;
    @(posedge clk);
    #1 pix_ready = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || res_ready !== 1'b1)
      $display("FAIL pop_release: pix_valid=%0b res_ready=%0b required 0 1", pix_valid, res_ready);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (res_ready !== 1'b1 || pix_valid !== 1'b0 || proto_err !== 1'b0)
      $display("FAIL reset_ctrl: rdy=%0b vld=%0b err=%0b required 1 0 0", res_ready, pix_valid, proto_err);
    else passed++;
    checks++;
    if (pix_hit !== 1'b0 || pix_light_mask !== 4'd0 || pix_x !== 9'd0 ||
        pix_sq_distance !== 16'd0 || pix_intersection !== 48'd0)
      $display("FAIL reset_pix: hit=%0b m=%b x=%0d d=%h i=%h required all 0",
               pix_hit, pix_light_mask, pix_x, pix_sq_distance, pix_intersection);
    else passed++;
  endtask

  task automatic test_nearest;
    logic        h [8] = '{0, 0, 1, 1, 0, 1, 0, 0};
    logic [15:0] d [8] = '{16'h3000, 16'h3000, 16'h4400, 16'hC000, 16'h3000, 16'h4200, 16'h3000, 16'h3000};
    for (int s = 0; s < 8; s++)
      send(h[s], d[s], {16'(s), 32'hA0A0_0000}, 3'(s), 1'b0, 2'd0, s == 7, 9'd1, 8'd2);
    checks++;
    if (pix_valid !== 1'b0 || res_ready !== 1'b1)
      $display("FAIL nearest_to_shadow: vld=%0b rdy=%0b required 0 1", pix_valid, res_ready);
    else passed++;
    for (int l = 0; l < 3; l++) shadow_miss(2'(l), 9'd1, 8'd2);
    checks++;
    if (pix_valid !== 1'b0)
      $display("FAIL nearest_early_emit: pix_valid=%0b required 0", pix_valid);
    else passed++;
    shadow_miss(2'd3, 9'd1, 8'd2);
    checks++;
    if (pix_valid !== 1'b1 || pix_hit !== 1'b1 || pix_shape_addr !== 3'd5 ||
        pix_sq_distance !== 16'h4200 || pix_light_mask !== 4'b1111 ||
        pix_intersection !== 48'h0005_A0A0_0000 || pix_x !== 9'd1 || pix_y !== 8'd2)
      $display("FAIL nearest_pix: vld=%0b hit=%0b shp=%0d d=%h m=%b i=%h xy=%0d,%0d required 1 1 5 4200 1111 0005a0a00000 1,2",
               pix_valid, pix_hit, pix_shape_addr, pix_sq_distance, pix_light_mask,
               pix_intersection, pix_x, pix_y);
    else passed++;
    pop_pixel(0, 1'b1, 3'd5, 16'h4200, 4'b1111, 9'd1, 8'd2);
  endtask

  task automatic test_all_miss;
    for (int s = 0; s < 8; s++)
      send(1'b0, 16'h3C00, 48'h0, 3'(s), 1'b0, 2'd0, s == 7, 9'd10, 8'd3);
    checks++;
    if (pix_valid !== 1'b1 || pix_hit !== 1'b0 || pix_light_mask !== 4'd0 ||
        pix_x !== 9'd10 || pix_y !== 8'd3 || res_ready !== 1'b0)
      $display("FAIL all_miss_pix: vld=%0b hit=%0b m=%b xy=%0d,%0d rdy=%0b required 1 0 0000 10,3 0",
               pix_valid, pix_hit, pix_light_mask, pix_x, pix_y, res_ready);
    else passed++;
    pop_pixel(0, 1'b0, 3'd0, 16'h7C00, 4'd0, 9'd10, 8'd3);
  endtask

  task automatic test_tie_self_shadow;
    for (int s = 0; s < 8; s++)
      send(s == 1 || s == 4, 16'h3C00, {16'(s), 32'h0}, 3'(s), 1'b0, 2'd0, s == 7, 9'd20, 8'd21);
    shadow_miss(2'd0, 9'd20, 8'd21);
    shadow_miss(2'd1, 9'd20, 8'd21);
    send(1'b1, 16'h3800, 48'h0, 3'd6, 1'b1, 2'd2, 1'b0, 9'd20, 8'd21);
    send(1'b1, 16'h3800, 48'h0, 3'd1, 1'b1, 2'd2, 1'b1, 9'd20, 8'd21);
    shadow_miss(2'd3, 9'd20, 8'd21);
    checks++;
    if (pix_valid !== 1'b1 || pix_shape_addr !== 3'd1 || pix_light_mask !== 4'b1011 ||
        pix_sq_distance !== 16'h3C00 || pix_intersection !== 48'h0001_0000_0000)
      $display("FAIL tie_pix: vld=%0b shp=%0d m=%b d=%h i=%h required 1 1 1011 3c00 000100000000",
               pix_valid, pix_shape_addr, pix_light_mask, pix_sq_distance, pix_intersection);
    else passed++;
    pop_pixel(5, 1'b1, 3'd1, 16'h3C00, 4'b1011, 9'd20, 8'd21);
  endtask

  task automatic test_proto_err;
    send(1'b1, 16'h4000, 48'h0000_0000_00AA, 3'd0, 1'b0, 2'd0, 1'b0, 9'd4, 8'd4);
    checks++;
    if (proto_err !== 1'b0)
      $display("FAIL proto_clean: proto_err=%0b required 0", proto_err);
    else passed++;
    send(1'b1, 16'h3000, 48'h0, 3'd3, 1'b1, 2'd0, 1'b0, 9'd4, 8'd4);
    checks++;
    if (proto_err !== 1'b1)
      $display("FAIL proto_shadow_in_primary: proto_err=%0b required 1", proto_err);
    else passed++;
    send(1'b1, 16'h3800, 48'h0, 3'd6, 1'b0, 2'd0, 1'b0, 9'd5, 8'd4);
    send(1'b0, 16'h3000, 48'h0, 3'd7, 1'b0, 2'd0, 1'b1, 9'd4, 8'd4);
    send(1'b1, 16'h3000, 48'h0, 3'd3, 1'b1, 2'd2, 1'b0, 9'd4, 8'd4);
    for (int l = 0; l < 4; l++) shadow_miss(2'(l), 9'd4, 8'd4);
    checks++;
    if (pix_valid !== 1'b1 || pix_hit !== 1'b1 || pix_shape_addr !== 3'd0 ||
        pix_sq_distance !== 16'h4000 || pix_intersection !== 48'h0000_0000_00AA ||
        pix_light_mask !== 4'b1111 || pix_x !== 9'd4 || pix_y !== 8'd4 || proto_err !== 1'b1)
      $display("FAIL proto_pix: vld=%0b hit=%0b shp=%0d d=%h i=%h m=%b xy=%0d,%0d err=%0b required 1 1 0 4000 0000000000aa 1111 4,4 1",
               pix_valid, pix_hit, pix_shape_addr, pix_sq_distance, pix_intersection,
               pix_light_mask, pix_x, pix_y, proto_err);
    else passed++;
    pop_pixel(0, 1'b1, 3'd0, 16'h4000, 4'b1111, 9'd4, 8'd4);
  endtask

  task automatic test_frame_start_and_rst;
    send(1'b1, 16'h4000, 48'h0, 3'd3, 1'b0, 2'd0, 1'b1, 9'd7, 8'd7);
    shadow_miss(2'd0, 9'd7, 8'd7);
    send(1'b1, 16'h3000, 48'h0, 3'd2, 1'b1, 2'd1, 1'b0, 9'd7, 8'd7);
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    checks++;
    if (res_ready !== 1'b1 || pix_valid !== 1'b0 || proto_err !== 1'b1)
      $display("FAIL frame_start_ctrl: rdy=%0b vld=%0b err=%0b required 1 0 1", res_ready, pix_valid, proto_err);
    else passed++;
    send(1'b1, 16'h3800, 48'h0000_0000_0BEE, 3'd6, 1'b0, 2'd0, 1'b1, 9'd8, 8'd9);
    shadow_miss(2'd0, 9'd8, 8'd9);
    send(1'b1, 16'h3000, 48'h0, 3'd2, 1'b1, 2'd1, 1'b1, 9'd8, 8'd9);
    shadow_miss(2'd2, 9'd8, 8'd9);
    checks++;
    if (pix_valid !== 1'b0)
      $display("FAIL frame_start_no_emit: pix_valid=%0b required 0", pix_valid);
    else passed++;
    shadow_miss(2'd3, 9'd8, 8'd9);
    checks++;
    if (pix_valid !== 1'b1 || pix_hit !== 1'b1 || pix_shape_addr !== 3'd6 ||
        pix_sq_distance !== 16'h3800 || pix_intersection !== 48'h0000_0000_0BEE ||
        pix_light_mask !== 4'b1101 || pix_x !== 9'd8 || pix_y !== 8'd9)
      $display("FAIL after_frame_start_pix: vld=%0b hit=%0b shp=%0d d=%h i=%h m=%b xy=%0d,%0d required 1 1 6 3800 000000000bee 1101 8,9",
               pix_valid, pix_hit, pix_shape_addr, pix_sq_distance, pix_intersection,
               pix_light_mask, pix_x, pix_y);
    else passed++;
    pop_pixel(0, 1'b1, 3'd6, 16'h3800, 4'b1101, 9'd8, 8'd9);
    send(1'b0, 16'h3000, 48'h0, 3'd0, 1'b0, 2'd0, 1'b1, 9'd1, 8'd1);
    checks++;
    if (pix_valid !== 1'b1)
      $display("FAIL rst_setup_emit: pix_valid=%0b required 1", pix_valid);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || res_ready !== 1'b1 || proto_err !== 1'b0 || pix_x !== 9'd0)
      $display("FAIL rst_mid_emit: vld=%0b rdy=%0b err=%0b x=%0d required 0 1 0 0",
               pix_valid, res_ready, proto_err, pix_x);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; res_valid = 1'b0; pix_ready = 1'b0;
    res_hit = 1'b0; res_sq_distance = '0; res_intersection = '0; res_shape_addr = '0;
    res_is_shadow = 1'b0; res_light_addr = '0; res_last = 1'b0;
    res_pixel_x = '0; res_pixel_y = '0;
    test_reset;
    test_nearest;
    test_all_miss;
    test_tie_self_shadow;
    test_proto_err;
    test_frame_start_and_rst;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
